// File: rtl/sccpu_mmio_pkg.sv
// sccpu_mmio_pkg: address map constants and serial transmit state encoding
package sccpu_mmio_pkg;
    localparam logic [23:0] MMIO_BASE = 24'hFFFFFF;
    localparam logic [15:0] RAM_TAG   = 16'h0000;
    localparam logic [7:0]  OFF_LED   = 8'h00;
    localparam logic [7:0]  OFF_SW    = 8'h04;
    localparam logic [7:0]  OFF_CYCLE = 8'h08;
    localparam logic [7:0]  OFF_TX    = 8'h0C;
    localparam logic [7:0]  OFF_TXCLR = 8'h10;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
endpackage

// File: rtl/uart_tx_ser.sv
// uart_tx_ser: 8N1 serial transmitter, one frame per start pulse while idle
module uart_tx_ser
    import sccpu_mmio_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] din,
    output logic       busy,
    output logic       tx
);
    localparam int CW = $clog2(BAUD_DIV + 1);
    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          bit_end;
    assign bit_end = cnt_q == CW'(BAUD_DIV - 1);
    // next-state: baud counter restarts each bit period, data shifts out LSB first
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        cnt_d   = (state_q == TX_IDLE || bit_end) ? '0 : cnt_q + 1'b1;
        case (state_q)
            TX_IDLE: if (start) begin
                state_d = TX_START;
                sh_d    = din;
            end
            TX_START: if (bit_end) state_d = TX_DATA;
            TX_DATA: if (bit_end) begin
                sh_d    = sh_q >> 1;
                bit_d   = bit_q + 3'd1;
                state_d = (bit_q == 3'd7) ? TX_STOP : TX_DATA;
            end
            TX_STOP: if (bit_end) state_d = TX_IDLE;
            default: state_d = TX_IDLE;
        endcase
    end
    // state register; reset abandons any frame in flight
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end
    assign busy = state_q != TX_IDLE;
    assign tx   = (state_q == TX_START) ? 1'b0 : (state_q == TX_DATA) ? sh_q[0] : 1'b1;
endmodule

// File: rtl/sccpu_dmem_bus.sv
// sccpu_dmem_bus: CPU data-memory responder decoding RAM, MMIO registers and serial TX
module sccpu_dmem_bus
    import sccpu_mmio_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int BAUD_DIV   = 434,
    parameter int SW_WIDTH   = 16
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [31:0]         addr,
    input  logic [31:0]         wdata,
    input  logic                wmem,
    output logic [31:0]         rdata,
    input  logic [SW_WIDTH-1:0] sw,
    output logic [15:0]         led,
    output logic                tx
);
    logic [31:0]           mem_q [2**ADDR_WIDTH];
    logic [15:0]           led_q, led_d;
    logic [31:0]           cycle_q, cycle_d;
    logic [SW_WIDTH-1:0]   sw_meta_q, sw_sync_q;
    logic                  ovr_q, ovr_d;
    logic                  is_ram, is_mmio, busy, tx_go;
    logic                  wr_led, wr_cycle, wr_tx, wr_clr;
    logic [7:0]            off;
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           mmio_rd;
    logic                  unused_addr;
    assign is_ram      = addr[31:16] == RAM_TAG;
    assign is_mmio     = addr[31:8] == MMIO_BASE;
    assign off         = {addr[7:2], 2'b00};
    assign idx         = addr[ADDR_WIDTH+1:2];
    assign unused_addr = ^{addr[1:0], addr[15:ADDR_WIDTH+2]};
    assign wr_led      = wmem && is_mmio && off == OFF_LED;
    assign wr_cycle    = wmem && is_mmio && off == OFF_CYCLE;
    assign wr_tx       = wmem && is_mmio && off == OFF_TX;
    assign wr_clr      = wmem && is_mmio && off == OFF_TXCLR;
    assign tx_go       = wr_tx && !busy;
    // word RAM: synchronous write, no reset
    always_ff @(posedge clock) begin
        if (wmem && is_ram) mem_q[idx] <= wdata;
    end
    // register next-state: a CYCLE write beats the increment, a TX write while busy flags overrun
    always_comb begin
        led_d   = wr_led ? wdata[15:0] : led_q;
        cycle_d = wr_cycle ? 32'd0 : cycle_q + 32'd1;
        ovr_d   = (wr_tx && busy) || (ovr_q && !wr_clr);
    end
    // MMIO state and two-flop switch synchroniser
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            led_q     <= '0;
            cycle_q   <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            ovr_q     <= 1'b0;
        end else begin
            led_q     <= led_d;
            cycle_q   <= cycle_d;
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
            ovr_q     <= ovr_d;
        end
    end
    // side-effect-free MMIO read mux; unmapped offsets return 0
    always_comb begin
        mmio_rd = 32'd0;
        case (off)
            OFF_LED:   mmio_rd = {16'd0, led_q};
            OFF_SW:    mmio_rd = 32'(sw_sync_q);
            OFF_CYCLE: mmio_rd = cycle_q;
            OFF_TX:    mmio_rd = {30'd0, ovr_q, busy};
            default:   mmio_rd = 32'd0;
        endcase
    end
    assign rdata = is_ram ? mem_q[idx] : is_mmio ? mmio_rd : 32'd0;
    assign led   = led_q;
    uart_tx_ser #(.BAUD_DIV(BAUD_DIV)) u_tx (
        .clock  (clock),
        .resetn (resetn),
        .start  (tx_go),
        .din    (wdata[7:0]),
        .busy   (busy),
        .tx     (tx)
    );
endmodule

// File: tb/tb_sccpu_dmem_bus.sv
// tb_sccpu_dmem_bus: directed scoreboard bench for the data-memory bus
module tb_sccpu_dmem_bus;
    localparam int B = 4;
    logic        clock = 1'b0, resetn = 1'b0, wmem = 1'b0, tx;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic [15:0] sw = '0, led;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          errors = 0, checks = 0;
    logic        ovr_m = 1'b0;

    sccpu_dmem_bus #(.ADDR_WIDTH(8), .BAUD_DIV(B), .SW_WIDTH(16)) dut (
        .clock  (clock),
        .resetn (resetn),
        .addr   (addr),
        .wdata  (wdata),
        .wmem   (wmem),
        .rdata  (rdata),
        .sw     (sw),
        .led    (led),
        .tx     (tx)
    );

    always #5 clock = ~clock;

    task automatic push(input string t, input logic [31:0] e);
        tag_q.push_back(t);
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        string t;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: got %h", obs);
            return;
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: got %h want %h", t, obs, e);
        end
    endtask

    task automatic rd(input string t, input logic [31:0] a, input logic [31:0] e);
        addr = a;
        wmem = 1'b0;
        push(t, e);
        #1;
        check(rdata);
    endtask

    task automatic pin(input string t, input logic [31:0] obs, input logic [31:0] e);
        push(t, e);
        check(obs);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wmem  = 1'b1;
        @(negedge clock);
        wmem  = 1'b0;
    endtask

    task automatic frame(input logic [7:0] b, input int w_at, input int c_at, input int n);
        for (int i = 0; i < n; i++) begin
            addr  = (i == c_at) ? 32'hFFFFFF10 : 32'hFFFFFF0C;
            wdata = 32'h000000AA;
            wmem  = (i == w_at) || (i == c_at);
            push("tx_line", (i < B) ? 32'd0 : (i < 9 * B) ? 32'(b[(i - B) / B]) : 32'd1);
            #1;
            check(32'(tx));
            push("tx_stat", (i == c_at) ? 32'd0 : {30'd0, ovr_m, i < 10 * B});
            check(rdata);
            if (i == w_at && i < 10 * B) ovr_m = 1'b1;
            if (i == c_at) ovr_m = 1'b0;
            @(negedge clock);
        end
        wmem = 1'b0;
    endtask

    initial begin
        #2;
        pin("rst_led", 32'(led), 32'd0);
        pin("rst_tx", 32'(tx), 32'd1);
        rd("rst_stat", 32'hFFFFFF0C, 32'd0);
        rd("rst_cycle", 32'hFFFFFF08, 32'd0);
        rd("rst_sw", 32'hFFFFFF04, 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        wr(32'h00000010, 32'hDEADBEEF);
        rd("ram_rd", 32'h00000010, 32'hDEADBEEF);
        rd("ram_misalign", 32'h00000013, 32'hDEADBEEF);
        rd("ram_alias", 32'h00000410, 32'hDEADBEEF);
        rd("unmapped_rd", 32'h00010000, 32'd0);
        wr(32'h00000014, 32'hCAFEF00D);
        rd("ram_rd2", 32'h00000014, 32'hCAFEF00D);
        rd("ram_keep", 32'h00000010, 32'hDEADBEEF);
        wr(32'h00010010, 32'h00000000);
        rd("unmapped_wr", 32'h00000010, 32'hDEADBEEF);
        addr  = 32'h00000010;
        wdata = 32'h11111111;
        wmem  = 1'b1;
        push("ram_rd_before_wr", 32'hDEADBEEF);
        #1;
        check(rdata);
        @(negedge clock);
        wmem = 1'b0;
        rd("ram_rd_after_wr", 32'h00000010, 32'h11111111);

        wr(32'hFFFFFF00, 32'h1234ABCD);
        pin("led_pin", 32'(led), 32'h0000ABCD);
        rd("led_rd", 32'hFFFFFF00, 32'h0000ABCD);
        wr(32'hFFFFFF14, 32'hFFFFFFFF);
        rd("undef_off", 32'hFFFFFF14, 32'd0);
        rd("txclr_rd", 32'hFFFFFF10, 32'd0);
        pin("led_keep", 32'(led), 32'h0000ABCD);
        wr(32'hFFFFFF04, 32'h0000FFFF);

        sw = 16'h00A5;
        rd("sw_n0", 32'hFFFFFF04, 32'd0);
        @(negedge clock);
        rd("sw_n1", 32'hFFFFFF04, 32'd0);
        @(negedge clock);
        rd("sw_n2", 32'hFFFFFF04, 32'h000000A5);

        wr(32'hFFFFFF08, 32'h12345678);
        rd("cycle_clr", 32'hFFFFFF08, 32'd0);
        repeat (3) @(negedge clock);
        rd("cycle_3", 32'hFFFFFF08, 32'd3);
        repeat (5) @(negedge clock);
        rd("cycle_8", 32'hFFFFFF08, 32'd8);

        wr(32'hFFFFFF0C, 32'h00000055);
        frame(8'h55, 12, 20, 10 * B + 5);
        wr(32'hFFFFFF0C, 32'h000000AA);
        frame(8'hAA, 10 * B - 1, -1, 10 * B + 2);
        wr(32'hFFFFFF10, 32'd0);
        ovr_m = 1'b0;
        rd("ovr_clr", 32'hFFFFFF0C, 32'd0);

        wr(32'hFFFFFF0C, 32'h00000055);
        repeat (2) @(negedge clock);
        pin("tx_mid", 32'(tx), 32'd0);
        addr   = 32'hFFFFFF0C;
        resetn = 1'b0;
        #1;
        pin("rst_async_tx", 32'(tx), 32'd1);
        pin("rst_async_led", 32'(led), 32'd0);
        rd("rst_async_stat", 32'hFFFFFF0C, 32'd0);
        rd("rst_async_cycle", 32'hFFFFFF08, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        pin("post_rst_tx", 32'(tx), 32'd1);
        rd("post_rst_stat", 32'hFFFFFF0C, 32'd0);
        rd("post_rst_cycle", 32'hFFFFFF08, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sccpu_dmem_bus.md
Name: sccpu_dmem_bus

Overview:
- Responder side of the single-cycle CPU data-memory port. The CPU drives address (its ALU result), write data and a write strobe; this block returns read data in the same cycle.
- Decodes each access to one of three targets: a word RAM, a small MMIO register set (LEDs, switches, cycle counter) or a serial transmit engine used by the board monitor.
- Sits between the CPU core and board pins in the monitor top level.

Parameters:
- ADDR_WIDTH, 8, word-index bits of RAM (2^ADDR_WIDTH words).
- BAUD_DIV, 434, clock cycles per serial bit (50 MHz / 115200).
- SW_WIDTH, 16, number of switch inputs.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- addr  in  32  byte address from CPU ALU; bits[1:0] ignored.
- wdata  in  32  store data from CPU.
- wmem  in  1  store strobe; the write takes effect at the rising edge while high.
- rdata  out  32  combinational read data returned to the CPU.
- sw  in  SW_WIDTH  asynchronous board switches.
- led  out  16  LED register.
- tx  out  1  serial transmit line; idles high.

Behaviour:
- Decode: RAM when addr[31:16]==0, index addr[ADDR_WIDTH+1:2]. MMIO when addr[31:8]==24'hFFFFFF. Any other address reads 0 and ignores writes. An undefined MMIO offset reads 0 and ignores writes.
- MMIO map (offset addr[7:0]):
  - 0x00 LED: RW, bits[15:0]; bits[31:16] read 0.
  - 0x04 SW: RO, zero-extended synchronised switches.
  - 0x08 CYCLE: read returns the counter; any write clears it.
  - 0x0C TXSTAT/TXDATA: read returns {30'b0, overrun, busy}; write sends wdata[7:0].
  - 0x10 TXCLR: a write clears overrun. Reads return 0.
- Reads are purely combinational with no side effects. rdata reflects the register or RAM state before the current edge's write.
- RAM: synchronous write, asynchronous read, not reset. Contents after power-up are undefined; the bench must not rely on them.
- Reset values: led=0, CYCLE=0, sync flops=0, tx=1, busy=0, overrun=0, bit counter=0, baud counter=0.
- SW synchroniser: two flops; a switch change becomes visible on the read path 2 edges later.
- CYCLE counter:
  - Increments by 1 every cycle and wraps 32'hFFFFFFFF to 0.
  - A write in the same cycle wins: the value after that edge is 0, and it counts from there.
- TX state machine: IDLE, START, DATA, STOP.
  - IDLE: tx=1, busy=0. A write to 0x0C latches the byte and moves to START on that edge; busy=1 from the next cycle.
  - START: tx=0 for BAUD_DIV cycles.
  - DATA: 8 bits, LSB first, BAUD_DIV cycles each; the 3-bit counter advances at each bit end.
  - STOP: tx=1 for BAUD_DIV cycles, then IDLE.
  - Total frame is exactly 10*BAUD_DIV cycles from the write edge until busy reads 0.
  - A write to 0x0C while busy=1 is dropped: the frame is unaffected and overrun is set (sticky).
  - A write to 0x0C in the same cycle STOP completes is also dropped, because busy is still 1 that cycle.
  - A simultaneous write to 0x10 and an overrun event cannot occur, since there is one access per cycle.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronously) and the state goes to IDLE; the partial frame is abandoned.
- Misaligned addresses are treated as the aligned word; there is no byte or halfword access.

Decomposition:
- Package sccpu_mmio_pkg:
  - Region base constants MMIO_BASE=24'hFFFFFF, RAM_TAG=16'h0000.
  - Offset constants OFF_LED, OFF_SW, OFF_CYCLE, OFF_TX, OFF_TXCLR.
  - TX state enum {TX_IDLE, TX_START, TX_DATA, TX_STOP}.
- Sub-module uart_tx_ser (parameter BAUD_DIV): holds the state machine, baud counter, shift register, tx and busy. Its ports are clock, resetn, start, din[7:0], busy, tx.
- The top level keeps the decode, RAM, LED, CYCLE, synchroniser and overrun logic.

Test Plan:
- Reset, then write RAM 0x00000010 = 0xDEADBEEF -> a read of 0x10 returns 0xDEADBEEF the next cycle. A read of 0x00000013 returns the same value. A read of 0x00010000 returns 0.
- Write 0xFFFFFF00 = 0x1234ABCD -> led=0xABCD and a read returns 0x0000ABCD. Reset mid-test -> led=0 asynchronously.
- Set sw=0x00A5 at cycle N -> a read of 0xFFFFFF04 returns 0x0 at N+1 and 0x000000A5 from N+2.
- Read CYCLE twice, 5 cycles apart -> the difference is 5. Write CYCLE at cycle M -> a read at M+3 returns 3. Force the count to 0xFFFFFFFF -> the next value is 0.
- With BAUD_DIV=4, write 0xFFFFFF0C = 0x55 -> tx reads 0, then 1,0,1,0,1,0,1,0, then 1, each held 4 cycles. busy=1 for 40 cycles, then status reads 0.
- During that frame, write 0x0C = 0xAA -> the frame is unchanged and status reads 0x3. Write 0x10 -> status reads 0x1. After the frame, write 0xAA -> a new frame starts normally.
